vscpu_mem_copier: RTL and testbench
===================================

# vscpu_mem_copier

Block-copy engine that sits beside VerySimpleCPU as a second initiator on the blram port. It uses the same `wrEn`/`addr_toRAM`/`data_toRAM`/`data_fromRAM` protocol and one-cycle registered-read latency as the CPU. On `start` it copies `len` consecutive 32-bit words from `src_addr` to `dst_addr`, then pulses `done`. The top level multiplexes it against the CPU; that arbitration is outside this block.

## Interface
- `SIZE`, default 14: RAM address width; all address and length arithmetic is modulo 2^SIZE.
- `clk`  in  1: single clock; all state on posedge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: copy request, sampled only in IDLE.
- `src_addr`  in  SIZE: first source word address, captured on accepted `start`.
- `dst_addr`  in  SIZE: first destination word address, captured on accepted `start`.
- `len`  in  SIZE: word count, captured on accepted `start`; 0 is legal.
- `busy`  out  1: high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1: one-cycle completion pulse.
- `checksum`  out  32: mod-2^32 sum of copied words; see Configuration.
- `wrEn`  out  1: RAM write enable.
- `addr_toRAM`  out  SIZE: RAM address.
- `data_toRAM`  out  32: RAM write data.
- `data_fromRAM`  in  32: RAM read data; valid in the cycle after its address was presented.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE. All outputs are registered.
- IDLE:
  - `busy`=0, `wrEn`=0.
  - On `start`=1, capture `src_addr`, `dst_addr` and `len`, and clear the word index `i`.
  - Go to READ, or to DONE if `len`=0.
- READ: `addr_toRAM`=src+i, `wrEn`=0.
- CAPTURE: address held, `wrEn`=0; register `data_fromRAM` into the word buffer at the end of the cycle.
- WRITE: `addr_toRAM`=dst+i, `wrEn`=1, `data_toRAM`=word buffer.
  - Increment `i`.
  - If `i`+1 == len go to DONE, else go to READ.
- DONE: `done`=1, `busy`=1 for one cycle, then IDLE.
- Address sums wrap modulo 2^SIZE; no error is flagged.
- Copy is strictly ascending. When dst lies in (src, src+len), copied data smears forward; this is the defined behaviour.
- `start` while not IDLE is ignored. Input changes after capture have no effect.
- `rst` asserted mid-copy:
  - Go to IDLE immediately (asynchronous).
  - `wrEn` drops with reset; any write not yet clocked is lost. Words already written stay written.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `wrEn`=0.
  - `addr_toRAM`=0, `data_toRAM`=0, `checksum`=0.
- Throughput is 3 cycles per word.
- With `start` accepted at edge E0, the first READ cycle follows E0.
- `done` is high in cycle 3·len+1 after E0. For `len`=0 that is cycle 1, with no RAM access.
- `wrEn` is never high outside WRITE.
- A new `start` can be accepted in the first IDLE cycle after DONE.

## Configuration
- `MEMCOPY_CHECKSUM_EN` defined:
  - `checksum` clears on accepted `start`.
  - Each captured word is added modulo 2^32.
  - The final value is stable from the DONE cycle until the next accepted `start`.
- Macro undefined: `checksum` is constant 0 and no adder is inferred. The port list is unchanged.

## Structure
- Package `vscpu_mem_pkg` holds:
  - the state enum type;
  - `VSCPU_DATA_W` = 32;
  - `VSCPU_ADDR_W` = 14.
- Optional sub-module `memcopy_csum`: accumulator with clear and enable. It is instantiated only under `MEMCOPY_CHECKSUM_EN`. All other logic stays in one module.

## Test plan
- Basic copy:
  - Stimulus: preload mem[100]=6, mem[101]=0; start with src=100, dst=200, len=2.
  - Required: mem[200]=6, mem[201]=0; `done` pulses exactly 7 cycles after the accepted start; exactly 2 `wrEn` cycles.
- Zero length:
  - Stimulus: start with len=0.
  - Required: `done` in cycle 1, `wrEn` never asserted, memory unchanged.
- Wrap-around:
  - Stimulus: src=16382, dst=0, len=3, with mem[16382..16383]=0xA, 0xB and mem[0]=0xC.
  - Required: mem[0]=0xA, mem[1]=0xB, mem[2]=0xA. mem[0] is overwritten before it is read as the third source word.
- Ignored start: a second `start` pulsed during an active copy has no effect; `done` pulses once and the first copy's timing is unchanged.
- Reset mid-copy:
  - Stimulus: `rst` low during the WRITE cycle of word 1 of a len=4 copy.
  - Required: outputs return to reset values immediately; only dst+0 is modified; a fresh start afterwards completes normally.
- Checksum (with `MEMCOPY_CHECKSUM_EN`):
  - Stimulus: copy mem[69]=1, mem[70]=0x3E8.
  - Required: `checksum`=0x3E9 at `done`. Without the macro, `checksum`=0 throughout.

Source files
------------

// File: rtl/vscpu_mem_pkg.sv
// Shared types and widths for the VerySimpleCPU block-copy engine.
package vscpu_mem_pkg;

  localparam int VSCPU_DATA_W = 32;
  localparam int VSCPU_ADDR_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } mc_state_e;

endpackage

// File: rtl/memcopy_csum.sv
// Running mod-2^W sum of copied words; clr has priority over en.
// One-cycle update latency; no backpressure (accepts a word whenever en_i is high).
module memcopy_csum #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)
      sum_d = '0;
    else if (en_i)
      sum_d = sum_q + din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/vscpu_mem_copier.sv
// Block copier on the blram port: 3 cycles/word (READ, CAPTURE, WRITE), done at cycle 3*len+1.
// No backpressure; optional running checksum under MEMCOPY_CHECKSUM_EN.
module vscpu_mem_copier
  import vscpu_mem_pkg::*;
#(
  parameter int SIZE = VSCPU_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SIZE-1:0]         src_addr,
  input  logic [SIZE-1:0]         dst_addr,
  input  logic [SIZE-1:0]         len,
  output logic                    busy,
  output logic                    done,
  output logic [VSCPU_DATA_W-1:0] checksum,
  output logic                    wrEn,
  output logic [SIZE-1:0]         addr_toRAM,
  output logic [VSCPU_DATA_W-1:0] data_toRAM,
  input  logic [VSCPU_DATA_W-1:0] data_fromRAM
);

  mc_state_e               state_q, state_d;
  logic [SIZE-1:0]         src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
  logic [SIZE-1:0]         addr_q, addr_d;
  logic [VSCPU_DATA_W-1:0] dat_q, dat_d;
  logic                    wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic                    accept;
  logic [SIZE-1:0]         idx_nxt;

  assign accept  = (state_q == ST_IDLE) && start;
  assign idx_nxt = idx_q + SIZE'(1);

  // Outputs are registered, so each state's bus values are set on entry.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    wr_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = len;
          idx_d  = '0;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_READ;
            addr_d  = src_addr;
          end
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_WRITE;
        dat_d   = data_fromRAM;
        addr_d  = dst_q + idx_q;
        wr_d    = 1'b1;
      end
      ST_WRITE: begin
        idx_d = idx_nxt;
        if (idx_nxt == len_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          addr_d  = src_q + idx_nxt;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wrEn       = wr_q;
  assign addr_toRAM = addr_q;
  assign data_toRAM = dat_q;

`ifdef MEMCOPY_CHECKSUM_EN
  memcopy_csum #(.W(VSCPU_DATA_W)) u_csum (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (accept),
    .en_i   (state_q == ST_CAPTURE),
    .din_i  (data_fromRAM),
    .sum_o  (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_vscpu_mem_copier.sv
// Randomized bench for vscpu_mem_copier against an array-based copy model.
module tb_vscpu_mem_copier;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
`ifdef MEMCOPY_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, len = '0;
  logic          busy, done, wrEn;
  logic [31:0]   checksum, data_toRAM, data_fromRAM;
  logic [AW-1:0] addr_toRAM;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        load = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  vscpu_mem_copier #(.SIZE(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .data_fromRAM (data_fromRAM)
  );

  always #5 clk = ~clk;

  // Registered-read RAM; 'load' copies the reference image in one cycle.
  always @(posedge clk) begin
    data_fromRAM <= mem[addr_toRAM];
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (wrEn) begin
      mem[addr_toRAM] <= data_toRAM;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // Reference: ascending word-by-word copy, modulo-wrapped addresses.
  function automatic logic [31:0] ref_copy(input int s, input int d, input int n);
    logic [31:0] sum = 0;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = ref_mem[(s + i) % DEPTH];
      sum += w;
      ref_mem[(d + i) % DEPTH] = w;
    end
    return sum;
  endfunction

  task automatic fill_and_load();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
  endtask

  task automatic push_image();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_wren"}, 32'(wrEn), 0);
    chk({pfx, "_addr"}, 32'(addr_toRAM), 0);
    chk({pfx, "_wdat"}, data_toRAM, 0);
    chk({pfx, "_csum"}, checksum, 0);
  endtask

  task automatic run_copy(input int s, input int d, input int n, input bit poke, input int rst_at,
                          output int done_at, output int wrs, output int dones,
                          output logic [31:0] cs);
    done_at = -1; wrs = 0; dones = 0; cs = 32'hdead_beef;
    @(negedge clk);
    start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); len = AW'(n);
    for (int k = 1; k <= 3 * n + 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        src_addr = AW'($urandom); dst_addr = AW'($urandom); len = AW'($urandom);
      end
      if (wrEn) wrs++;
      if (done) begin
        dones++;
        if (done_at < 0) begin done_at = k; cs = checksum; end
      end
      if (rst_at == k) begin
        rst = 1'b0;
        start = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        break;
      end
      start = poke && (k == 2);
    end
    start = 1'b0;
  endtask

  int          dat, wrs, dns, s, d, n;
  logic [31:0] cs, exp_cs;
  bit          poke;

  initial begin
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // basic copy
    fill_and_load();
    ref_mem[100] = 6; ref_mem[101] = 0;
    push_image();
    run_copy(100, 200, 2, 1'b0, 0, dat, wrs, dns, cs);
    exp_cs = ref_copy(100, 200, 2);
    chk("basic_done_cyc", 32'(dat), 7);
    chk("basic_wr_cnt", 32'(wrs), 2);
    chk("basic_done_cnt", 32'(dns), 1);
    chk("basic_m200", mem[200], 6);
    chk("basic_m201", mem[201], 0);
    chk("basic_diff", 32'(mem_diff()), 0);

    // zero length
    run_copy(300, 400, 0, 1'b0, 0, dat, wrs, dns, cs);
    chk("zero_done_cyc", 32'(dat), 1);
    chk("zero_wr_cnt", 32'(wrs), 0);
    chk("zero_done_cnt", 32'(dns), 1);
    chk("zero_csum", cs, 0);
    chk("zero_diff", 32'(mem_diff()), 0);

    // wrap-around with overwrite-before-read
    ref_mem[16382] = 32'hA; ref_mem[16383] = 32'hB; ref_mem[0] = 32'hC;
    push_image();
    run_copy(16382, 0, 3, 1'b0, 0, dat, wrs, dns, cs);
    exp_cs = ref_copy(16382, 0, 3);
    chk("wrap_m0", mem[0], 32'hA);
    chk("wrap_m1", mem[1], 32'hB);
    chk("wrap_m2", mem[2], 32'hA);
    chk("wrap_done_cyc", 32'(dat), 10);
    chk("wrap_csum", cs, CS_EN ? exp_cs : 32'h0);
    chk("wrap_diff", 32'(mem_diff()), 0);

    // start during an active copy is ignored
    run_copy(500, 900, 5, 1'b1, 0, dat, wrs, dns, cs);
    exp_cs = ref_copy(500, 900, 5);
    chk("ign_done_cyc", 32'(dat), 16);
    chk("ign_done_cnt", 32'(dns), 1);
    chk("ign_wr_cnt", 32'(wrs), 5);
    chk("ign_diff", 32'(mem_diff()), 0);

    // checksum
    ref_mem[69] = 1; ref_mem[70] = 32'h3E8;
    push_image();
    run_copy(69, 1000, 2, 1'b0, 0, dat, wrs, dns, cs);
    exp_cs = ref_copy(69, 1000, 2);
    chk("csum_val", cs, CS_EN ? 32'h3E9 : 32'h0);
    chk("csum_model", exp_cs, 32'h3E9 + 32'(mem_diff()));

    // reset during WRITE of word 1: only dst+0 lands
    fill_and_load();
    push_image();
    run_copy(2000, 3000, 4, 1'b0, 6, dat, wrs, dns, cs);
    exp_cs = ref_copy(2000, 3000, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    chk("rst_diff", 32'(mem_diff()), 0);
    chk("rst_dst1", mem[3001], ref_mem[3001]);
    run_copy(2000, 3000, 4, 1'b0, 0, dat, wrs, dns, cs);
    exp_cs = ref_copy(2000, 3000, 4);
    chk("rst_again_cyc", 32'(dat), 13);
    chk("rst_again_csum", cs, CS_EN ? exp_cs : 32'h0);
    chk("rst_again_diff", 32'(mem_diff()), 0);

    // randomized copies, including overlapping and wrapping ranges
    for (int t = 0; t < 10; t++) begin
      s = $urandom_range(0, DEPTH - 1);
      d = (t % 3 == 0) ? (s + $urandom_range(1, 6)) % DEPTH : $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 12);
      poke = (n >= 1) && $urandom_range(0, 1) == 1;
      run_copy(s, d, n, poke, 0, dat, wrs, dns, cs);
      exp_cs = ref_copy(s, d, n);
      chk($sformatf("rnd%0d_done_cyc", t), 32'(dat), 32'(3 * n + 1));
      chk($sformatf("rnd%0d_wr_cnt", t), 32'(wrs), 32'(n));
      chk($sformatf("rnd%0d_done_cnt", t), 32'(dns), 1);
      chk($sformatf("rnd%0d_csum", t), cs, CS_EN ? exp_cs : 32'h0);
      chk($sformatf("rnd%0d_diff", t), 32'(mem_diff()), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
